line_buffer_ctrl: RTL

Write/read controller for the pyramid line buffers. It takes a raster pixel stream and writes each line into one of NO_RAM line memories in rotation, reading every line memory at the same column. It emits a vertical column of NO_RAM+1 pixels (the current pixel plus the NO_RAM previous lines) to the downstream vertical filter. It drives the generic memory wrapper directly, with the wrapper in 1R1W mode.

---
 rtl/line_buffer_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/line_buffer_ctrl.sv
// Line buffer write/read controller: rotates raster lines through NO_RAM
// memories and emits a NO_RAM+1 pixel vertical column per accepted pixel.
module line_buffer_ctrl #(
    parameter int NO_RAM = 4,
    parameter int DW     = 12,
    parameter int AW     = 11,
    parameter int IMG_W  = 1920
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_sof,
    output logic [NO_RAM-1:0]        mem_wr_en,
    output logic [NO_RAM*AW-1:0]     mem_wr_addr,
    output logic [NO_RAM*DW-1:0]     mem_wr_data,
    output logic [NO_RAM-1:0]        mem_rd_en,
    output logic [NO_RAM*AW-1:0]     mem_rd_addr,
    input  logic [NO_RAM*DW-1:0]     mem_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(NO_RAM+1)*DW-1:0] out_col,
    output logic [AW-1:0]            out_x,
    output logic                     out_row_ok
);

    localparam int SW = (NO_RAM > 1) ? $clog2(NO_RAM) : 1;
    localparam int FW = $clog2(NO_RAM + 1);
    localparam logic [AW-1:0] X_LAST   = AW'(IMG_W - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(NO_RAM - 1);
    localparam logic [FW-1:0] FULL     = FW'(NO_RAM);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t        state;
    logic [AW-1:0] x;
    logic [SW-1:0] wr_sel;
    logic [FW-1:0] rows_filled;
    logic [SW-1:0] col_sel;
    logic [DW-1:0] col_pix;

    logic          accept;
    logic          proc;
    logic          line_end;
    logic [AW-1:0] cur_x;
    logic [SW-1:0] cur_sel;
    logic [FW-1:0] cur_filled;
    logic [FW-1:0] next_filled;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    // Pixels arriving before the first start-of-frame are simply dropped.
    assign proc     = accept & ~rst & ((state != IDLE) | in_sof);

    assign cur_x       = in_sof ? '0 : x;
    assign cur_sel     = in_sof ? '0 : wr_sel;
    assign cur_filled  = in_sof ? '0 : rows_filled;
    assign line_end    = (cur_x == X_LAST);
    assign next_filled = (cur_filled == FULL) ? FULL : cur_filled + 1'b1;

    always_comb begin
        for (int i = 0; i < NO_RAM; i++) begin
            mem_wr_en[i] = proc && (cur_sel == SW'(i));
        end
        mem_rd_en   = {NO_RAM{proc}};
        mem_wr_addr = {NO_RAM{cur_x}};
        mem_rd_addr = {NO_RAM{cur_x}};
        mem_wr_data = {NO_RAM{in_data}};
    end

    // Read data is held by the memories while rd_en is low, so the column
    // stays stable under back-pressure without a capture register.
    always_comb begin
        out_col = '0;
        if (out_valid) begin
            out_col[0 +: DW] = col_pix;
            for (int k = 1; k <= NO_RAM; k++) begin
                out_col[k*DW +: DW] =
                    mem_rd_data[((int'(col_sel) + NO_RAM - k) % NO_RAM)*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            wr_sel      <= '0;
            rows_filled <= '0;
            out_valid   <= 1'b0;
            out_row_ok  <= 1'b0;
            out_x       <= '0;
            col_sel     <= '0;
            col_pix     <= '0;
        end else if (proc) begin
            out_valid  <= 1'b1;
            out_x      <= cur_x;
            out_row_ok <= (cur_filled >= FULL);
            col_pix    <= in_data;
            col_sel    <= cur_sel;
            if (line_end) begin
                x           <= '0;
                wr_sel      <= (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;
                rows_filled <= next_filled;
                state       <= (next_filled == FULL) ? RUN : FILL;
            end else begin
                x           <= cur_x + 1'b1;
                wr_sel      <= cur_sel;
                rows_filled <= cur_filled;
                state       <= (in_sof || state == IDLE) ? FILL : state;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
